sid_voice_sched: RTL and testbench
==================================

Name: sid_voice_sched

Overview:
- Time-multiplexes one shared voice waveform/DCA datapath across N_VOICES voices.
- On each sample tick, issues voice indices 0..N_VOICES-1 to the datapath, one per clk cycle. Returns on-chip voice outputs are captured into per-voice holding registers, and the OSC3 readback is captured from voice index 2.
- Sits between the per-voice oscillator/envelope state (muxed by sel_o) and the filter/mixer stage, which consumes voices_o on done_o.

Parameters:
- N_VOICES, 3, number of voices sharing the datapath (2..8).
- LATENCY, 1, clk cycles from a datapath input being presented to its voice/osc output being valid (1..4).
- OSC3_IDX, 2, voice index whose osc output is latched to osc3_o (< N_VOICES).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- tick  in  1  one-cycle sample strobe; starts a scheduling round.
- mute_i  in  N_VOICES  per-voice mute (voice3off); effective only with the optional feature.
- sel_o  out  $clog2(N_VOICES)  voice index presented to the datapath input mux.
- sel_valid_o  out  1  sel_o is issuing a real voice this cycle.
- dp_voice_i  in  22 (signed)  datapath voice_o.
- dp_osc_i  in  8  datapath osc_o.
- voices_o  out  N_VOICES x 22 (signed, packed, index 0 in LSBs)  captured voice outputs.
- osc3_o  out  8  captured osc output of voice OSC3_IDX.
- busy_o  out  1  round in progress.
- done_o  out  1  one-cycle strobe; all captures of the round are visible on voices_o.
- overrun_o  out  1  sticky; a tick arrived while busy_o was high.

Behaviour:
- Single clock domain (clk). Reset is synchronous, active-high (rst).
- Reset values:
  - sel_o=0, sel_valid_o=0, busy_o=0, done_o=0, overrun_o=0.
  - voices_o all 0, osc3_o=0.
  - Capture pipeline cleared.
- rst mid-round aborts the round immediately. No done_o is produced, and no capture occurs on the cycle after rst.
- FSM states: IDLE, ISSUE, DRAIN.
  - IDLE: on tick, go to ISSUE and set k=0. busy_o goes high in the next cycle.
  - ISSUE: sel_o=k, sel_valid_o=1. k increments each cycle. After k=N_VOICES-1, go to DRAIN.
  - DRAIN: sel_valid_o=0, sel_o holds its last value. Stay for LATENCY cycles, until the last capture is made, then return to IDLE. done_o is asserted in the cycle the registers show the final value; busy_o drops in that same cycle.
- Capture pipeline:
  - Shift register LATENCY deep carrying {valid, idx}.
  - When the pipeline output is valid, on the clk edge: voices_o[idx] <= dp_voice_i; if idx==OSC3_IDX, osc3_o <= dp_osc_i.
- Round length: tick sampled at cycle t.
  - First issue occurs at t+1, last issue at t+N_VOICES.
  - Last capture edge is at the end of cycle t+N_VOICES+LATENCY.
  - done_o is high at cycle t+N_VOICES+LATENCY+1; busy_o is high from t+1 through t+N_VOICES+LATENCY.
  - Defaults (N_VOICES=3, LATENCY=1): done_o is high at t+5.
- tick while busy_o=1 (including the done_o cycle) is ignored and sets overrun_o. overrun_o clears only on rst.
- tick in IDLE in the cycle after done_o starts a new round normally.
- voices_o entries not yet recaptured in a round hold their previous-round values. Consumers read only on done_o.
- sel_o wraps to 0 only at the next round start, never mid-round.

Optional Feature:
- Macro SID_VOICE_SCHED_MUTE_EN.
- Defined:
  - A voice whose mute_i bit is high at its capture edge stores 0 into voices_o[idx].
  - osc3_o is still captured from dp_osc_i regardless of mute, matching voice3off semantics.
- Undefined:
  - mute_i is ignored (unused), and all captures store dp_voice_i.
  - The mute logic is not synthesized.

Test Plan:
- Reset then idle (N=3, L=1): all outputs are 0 and stay 0 with no tick.
- Basic round: tick at cycle 10; the datapath model returns dp_voice_i = 22'h1000*(sel+1) and dp_osc_i = 8'h40+sel, one cycle after issue.
  - sel_o/sel_valid_o show 0,1,2 on cycles 11-13.
  - done_o is high at cycle 15.
  - voices_o = {22'h3000, 22'h2000, 22'h1000}, osc3_o = 8'h42.
- Overrun: tick at 10 and again at 12 → second tick ignored, overrun_o=1 from cycle 13, single done_o at 15. A further tick at 16 → normal round, done_o at 21.
- Reset mid-round: tick at 10, rst at 12 → at cycle 13 all outputs are 0, and done_o never asserts. A tick at 14 → done_o at 19.
- LATENCY=3, N_VOICES=3: tick at 10 → captures at the ends of cycles 14, 15, 16; done_o at 17.
- With SID_VOICE_SCHED_MUTE_EN, mute_i=3'b100, dp_voice_i=22'h0ABCDE, dp_osc_i=8'h5A for all voices → voices_o[2]=0, voices_o[1:0]=22'h0ABCDE, osc3_o=8'h5A. Without the macro → voices_o[2]=22'h0ABCDE.

Source files
------------

// File: rtl/sid_voice_sched.sv
// rtl/sid_voice_sched.sv - round scheduler sharing one voice datapath across N_VOICES voices
// Optional build macro: SID_VOICE_SCHED_MUTE_EN (per-voice mute forces captured voice output to 0)
module sid_voice_sched #(
   parameter int N_VOICES = 3,
   parameter int LATENCY  = 1,
   parameter int OSC3_IDX = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           tick,
   input  logic [N_VOICES-1:0]            mute_i,
   output logic [$clog2(N_VOICES)-1:0]    sel_o,
   output logic                           sel_valid_o,
   input  logic signed [21:0]             dp_voice_i,
   input  logic [7:0]                     dp_osc_i,
   output logic signed [N_VOICES*22-1:0]  voices_o,
   output logic [7:0]                     osc3_o,
   output logic                           busy_o,
   output logic                           done_o,
   output logic                           overrun_o
);

   localparam int SW = $clog2(N_VOICES);
   localparam logic [SW-1:0] LAST_SEL   = SW'(N_VOICES - 1);
   localparam logic [SW-1:0] OSC3_SEL   = SW'(OSC3_IDX);
   localparam logic [2:0]    LAST_DRAIN = 3'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

   state_t        state_q, state_n;
   logic [SW-1:0] sel_n;
   logic          sel_valid_n;
   logic [2:0]    cnt_q, cnt_n;
   logic          done_n;
   logic          overrun_n;

   // {valid, idx} of each issued voice, delayed to line up with the datapath result
   logic [LATENCY-1:0] pv_q;
   logic [SW-1:0]      pidx_q [LATENCY];
   logic               cap_valid;
   logic [SW-1:0]      cap_idx;
   logic [21:0]        cap_data;

   assign busy_o    = (state_q != IDLE);
   assign cap_valid = pv_q[LATENCY-1];
   assign cap_idx   = pidx_q[LATENCY-1];

`ifdef SID_VOICE_SCHED_MUTE_EN
   // muted voices store silence; osc3 readback still follows the oscillator
   always_comb begin
      cap_data = dp_voice_i;
      if (mute_i[cap_idx]) cap_data = '0;
   end
`else
   logic mute_unused;
   assign mute_unused = ^mute_i;
   assign cap_data    = dp_voice_i;
`endif

   // next-state and next-output decode; a tick during a round or its done cycle only flags overrun
   always_comb begin
      state_n     = state_q;
      sel_n       = sel_o;
      sel_valid_n = 1'b0;
      cnt_n       = cnt_q;
      done_n      = 1'b0;
      overrun_n   = overrun_o;
      if (tick && (state_q != IDLE || done_o)) overrun_n = 1'b1;
      case (state_q)
         IDLE: begin
            if (tick && !done_o) begin
               state_n     = ISSUE;
               sel_n       = '0;
               sel_valid_n = 1'b1;
            end
         end
         ISSUE: begin
            if (sel_o == LAST_SEL) begin
               state_n = DRAIN;
               cnt_n   = 3'd0;
            end else begin
               sel_n       = sel_o + SW'(1);
               sel_valid_n = 1'b1;
            end
         end
         DRAIN: begin
            if (cnt_q == LAST_DRAIN) begin
               state_n = IDLE;
               done_n  = 1'b1;
            end else begin
               cnt_n = cnt_q + 3'd1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // state and registered scheduler outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         sel_o       <= '0;
         sel_valid_o <= 1'b0;
         cnt_q       <= 3'd0;
         done_o      <= 1'b0;
         overrun_o   <= 1'b0;
      end else begin
         state_q     <= state_n;
         sel_o       <= sel_n;
         sel_valid_o <= sel_valid_n;
         cnt_q       <= cnt_n;
         done_o      <= done_n;
         overrun_o   <= overrun_n;
      end
   end

   // capture pipeline shift; cleared on reset so an aborted round never captures
   always_ff @(posedge clk) begin
      if (rst) begin
         pv_q <= '0;
         for (int i = 0; i < LATENCY; i++) pidx_q[i] <= '0;
      end else begin
         pv_q[0]   <= sel_valid_o;
         pidx_q[0] <= sel_o;
         for (int i = 1; i < LATENCY; i++) begin
            pv_q[i]   <= pv_q[i-1];
            pidx_q[i] <= pidx_q[i-1];
         end
      end
   end

   // per-voice holding registers, written when the pipeline presents a valid index
   always_ff @(posedge clk) begin
      if (rst) begin
         voices_o <= '0;
         osc3_o   <= 8'h00;
      end else if (cap_valid) begin
         voices_o[int'(cap_idx)*22 +: 22] <= cap_data;
         if (cap_idx == OSC3_SEL) osc3_o <= dp_osc_i;
      end
   end

endmodule

// File: tb/tb_sid_voice_sched.sv
// tb/tb_sid_voice_sched.sv - checks sid_voice_sched at LATENCY 1 and 3 against a timing-rule model
module tb_sid_voice_sched;

   localparam int N = 3;

   logic               clk, rst, tick;
   logic [N-1:0]       mute;
   logic               dp_mode;
   logic [1:0]         sel    [2];
   logic               selv   [2];
   logic               busy   [2];
   logic               done   [2];
   logic               ovr    [2];
   logic [N*22-1:0]    vo     [2];
   logic [7:0]         o3     [2];
   logic signed [21:0] dpv    [2];
   logic [7:0]         dpo    [2];
   logic [1:0]         hist   [2][4];

   int cyc      = 0;
   int n_checks = 0;
   int n_pass   = 0;

   int          st   [2] = '{-1, -1};
   logic        m_ovr[2] = '{1'b0, 1'b0};
   logic [21:0] m_v  [2][N];
   logic [7:0]  m_o3 [2];
   logic [1:0]  m_sel[2] = '{2'd0, 2'd0};

   sid_voice_sched #(.N_VOICES(N), .LATENCY(1), .OSC3_IDX(2)) u_dut (
      .clk(clk), .rst(rst), .tick(tick), .mute_i(mute),
      .sel_o(sel[0]), .sel_valid_o(selv[0]),
      .dp_voice_i(dpv[0]), .dp_osc_i(dpo[0]),
      .voices_o(vo[0]), .osc3_o(o3[0]),
      .busy_o(busy[0]), .done_o(done[0]), .overrun_o(ovr[0])
   );

   sid_voice_sched #(.N_VOICES(N), .LATENCY(3), .OSC3_IDX(2)) u_dut3 (
      .clk(clk), .rst(rst), .tick(tick), .mute_i(mute),
      .sel_o(sel[1]), .sel_valid_o(selv[1]),
      .dp_voice_i(dpv[1]), .dp_osc_i(dpo[1]),
      .voices_o(vo[1]), .osc3_o(o3[1]),
      .busy_o(busy[1]), .done_o(done[1]), .overrun_o(ovr[1])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int lat_of(int j);
      return (j == 0) ? 1 : 3;
   endfunction

   function automatic logic [21:0] dp_voice_of(int s);
      if (dp_mode) return 22'h0ABCDE;
      return 22'(32'h1000 * (s + 1));
   endfunction

   function automatic logic [7:0] dp_osc_of(int s);
      if (dp_mode) return 8'h5A;
      return 8'(8'h40 + s);
   endfunction

   function automatic logic [21:0] exp_capture(int k);
`ifdef SID_VOICE_SCHED_MUTE_EN
      if (mute[k]) return 22'h0;
`endif
      return dp_voice_of(k);
   endfunction

   function automatic bit valid_at(int j, int c);
      return st[j] >= 0 && c >= st[j] + 1 && c <= st[j] + N;
   endfunction

   function automatic bit busy_at(int j, int c);
      return st[j] >= 0 && c >= st[j] + 1 && c <= st[j] + N + lat_of(j);
   endfunction

   function automatic bit done_at(int j, int c);
      return st[j] >= 0 && c == st[j] + N + lat_of(j) + 1;
   endfunction

   // datapath stand-in: answers for the voice issued LATENCY cycles earlier
   always @(posedge clk) begin
      for (int j = 0; j < 2; j++) begin
         hist[j][0] <= sel[j];
         for (int i = 1; i < 4; i++) hist[j][i] <= hist[j][i-1];
      end
   end

   always_comb begin
      dpv[0] = dp_voice_of(int'(hist[0][0]));
      dpo[0] = dp_osc_of(int'(hist[0][0]));
      dpv[1] = dp_voice_of(int'(hist[1][2]));
      dpo[1] = dp_osc_of(int'(hist[1][2]));
   end

   // model: round start cycle plus timing rules give every output for every cycle
   always @(posedge clk) begin
      for (int j = 0; j < 2; j++) begin
         if (rst) begin
            st[j]    = -1;
            m_ovr[j] = 1'b0;
            m_o3[j]  = 8'h00;
            m_sel[j] = 2'd0;
            for (int k = 0; k < N; k++) m_v[j][k] = 22'h0;
         end else begin
            if (st[j] >= 0) begin
               int k;
               k = cyc - st[j] - 1 - lat_of(j);
               if (k >= 0 && k < N) begin
                  m_v[j][k] = exp_capture(k);
                  if (k == 2) m_o3[j] = dp_osc_of(k);
               end
            end
            if (tick) begin
               if (busy_at(j, cyc) || done_at(j, cyc)) m_ovr[j] = 1'b1;
               else st[j] = cyc;
            end
         end
      end
      cyc = cyc + 1;
      for (int j = 0; j < 2; j++)
         if (valid_at(j, cyc)) m_sel[j] = 2'(cyc - st[j] - 1);
   end

   task automatic chk(input string nm, input int j, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s[%0d] cyc=%0d got=%h want=%h", nm, j, cyc, act, exp);
   endtask

   // per-cycle compare of both instances against the model
   always @(negedge clk) begin
      if (cyc >= 1) begin
         for (int j = 0; j < 2; j++) begin
            chk("sel_valid", j, 32'(selv[j]), 32'(valid_at(j, cyc)));
            chk("sel", j, 32'(sel[j]), 32'(m_sel[j]));
            chk("busy", j, 32'(busy[j]), 32'(busy_at(j, cyc)));
            chk("done", j, 32'(done[j]), 32'(done_at(j, cyc)));
            chk("overrun", j, 32'(ovr[j]), 32'(m_ovr[j]));
            chk("osc3", j, 32'(o3[j]), 32'(m_o3[j]));
            for (int k = 0; k < N; k++)
               chk("voice", j, 32'(vo[j][k*22 +: 22]), 32'(m_v[j][k]));
         end
      end
   end

   task automatic at_cycle(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   // directed stimulus with hand-computed expectations
   initial begin
      logic [21:0] want_v2;
      rst = 1'b1; tick = 1'b0; mute = '0; dp_mode = 1'b0;
      at_cycle(2);  rst = 1'b0;
      at_cycle(5);
      chk("lit_idle_busy", 0, 32'(busy[0]), 32'd0);
      chk("lit_idle_v0", 0, 32'(vo[0][21:0]), 32'd0);

      // basic round
      at_cycle(10); tick = 1'b1;
      at_cycle(11); tick = 1'b0;
      chk("lit_sel11", 0, 32'({selv[0], sel[0]}), 32'h4);
      at_cycle(12); chk("lit_sel12", 0, 32'({selv[0], sel[0]}), 32'h5);
      at_cycle(13); chk("lit_sel13", 0, 32'({selv[0], sel[0]}), 32'h6);
      at_cycle(14); chk("lit_done14", 0, 32'(done[0]), 32'd0);
      at_cycle(15);
      chk("lit_done15", 0, 32'(done[0]), 32'd1);
      chk("lit_v0", 0, 32'(vo[0][21:0]), 32'h1000);
      chk("lit_v1", 0, 32'(vo[0][43:22]), 32'h2000);
      chk("lit_v2", 0, 32'(vo[0][65:44]), 32'h3000);
      chk("lit_osc3", 0, 32'(o3[0]), 32'h42);
      at_cycle(16); chk("lit_l3_done16", 1, 32'(done[1]), 32'd0);
      at_cycle(17);
      chk("lit_l3_done17", 1, 32'(done[1]), 32'd1);
      chk("lit_l3_v2", 1, 32'(vo[1][65:44]), 32'h3000);

      // overrun, then normal and back-to-back rounds
      at_cycle(20); rst = 1'b1;
      at_cycle(21); rst = 1'b0;
      at_cycle(35); tick = 1'b1;
      at_cycle(36); tick = 1'b0;
      at_cycle(37); tick = 1'b1;
      at_cycle(38); tick = 1'b0;
      chk("lit_ovr38", 0, 32'(ovr[0]), 32'd1);
      at_cycle(40); chk("lit_done40", 0, 32'(done[0]), 32'd1);
      at_cycle(41); tick = 1'b1;
      at_cycle(42); tick = 1'b0;
      at_cycle(46); chk("lit_done46", 0, 32'(done[0]), 32'd1);
      at_cycle(47); tick = 1'b1;
      at_cycle(48); tick = 1'b0;
      at_cycle(52); chk("lit_done52", 0, 32'(done[0]), 32'd1);

      // reset mid-round
      at_cycle(55); rst = 1'b1;
      at_cycle(56); rst = 1'b0;
      at_cycle(65); tick = 1'b1;
      at_cycle(66); tick = 1'b0;
      at_cycle(67); rst = 1'b1;
      at_cycle(68); rst = 1'b0;
      chk("lit_abort_busy", 0, 32'(busy[0]), 32'd0);
      chk("lit_abort_sel", 0, 32'({selv[0], sel[0]}), 32'd0);
      at_cycle(69); tick = 1'b1;
      at_cycle(70); tick = 1'b0;
      at_cycle(74); chk("lit_done74", 0, 32'(done[0]), 32'd1);

      // constant datapath with voice 2 muted
      at_cycle(80); rst = 1'b1;
      at_cycle(81); rst = 1'b0; dp_mode = 1'b1; mute = 3'b100;
      at_cycle(95); tick = 1'b1;
      at_cycle(96); tick = 1'b0;
`ifdef SID_VOICE_SCHED_MUTE_EN
      want_v2 = 22'h0;
`else
      want_v2 = 22'h0ABCDE;
`endif
      at_cycle(100);
      chk("lit_mute_v2", 0, 32'(vo[0][65:44]), 32'(want_v2));
      chk("lit_mute_v1", 0, 32'(vo[0][43:22]), 32'h0ABCDE);
      chk("lit_mute_v0", 0, 32'(vo[0][21:0]), 32'h0ABCDE);
      chk("lit_mute_osc3", 0, 32'(o3[0]), 32'h5A);
      at_cycle(102);
      chk("lit_l3_mute_v2", 1, 32'(vo[1][65:44]), 32'(want_v2));

      at_cycle(106);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
